axil_bram_banks: RTL and testbench
==================================

AXIL_BRAM_BANKS -- requirements
Module: axil_bram_banks

Interface
REQ-001 SHALL have parameter N_BANKS, default 2: number of BRAM banks, 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: log2 of 32-bit words per bank, 4..12.
REQ-003 SHALL have parameter AXI_WR_EN, default 1: 0 makes the AXI side read-only.
REQ-004 axi_clock  in  1  sole clock, rising edge; one clock only.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_axil_awaddr  in  32  write byte address.
REQ-007 s_axil_awvalid  in  1  write address valid.
REQ-008 s_axil_awready  out  1  write address accept.
REQ-009 s_axil_wdata  in  32  write data.
REQ-010 s_axil_wstrb  in  4  byte enables.
REQ-011 s_axil_wvalid  in  1  write data valid.
REQ-012 s_axil_wready  out  1  write data accept.
REQ-013 s_axil_bresp  out  2  write response: OKAY=00, SLVERR=10.
REQ-014 s_axil_bvalid  out  1  write response valid.
REQ-015 s_axil_bready  in  1  write response accept.
REQ-016 s_axil_araddr  in  32  read byte address.
REQ-017 s_axil_arvalid  in  1  read address valid.
REQ-018 s_axil_arready  out  1  read address accept.
REQ-019 s_axil_rdata  out  32  read data.
REQ-020 s_axil_rresp  out  2  read response.
REQ-021 s_axil_rvalid  out  1  read data valid.
REQ-022 s_axil_rready  in  1  read data accept.
REQ-023 pl_we  in  1  fabric-side full-word write enable.
REQ-024 pl_bank  in  BANK_BITS=max(1,clog2(N_BANKS))  fabric bank select.
REQ-025 pl_addr  in  DEPTH_LOG2  fabric word address.
REQ-026 pl_din  in  32  fabric write data.
REQ-027 pl_dout  out  32  fabric read data, read-first, 1-cycle latency, every cycle.

Function
REQ-028 Address decode SHALL be: word = addr[DEPTH_LOG2+1:2]; bank = addr[DEPTH_LOG2+2 +: BANK_BITS]; addr[1:0] and higher bits ignored.
REQ-029 A bank index >= N_BANKS SHALL get SLVERR: writes change no memory; reads return rdata 0.
REQ-030 With AXI_WR_EN=0, every AXI write SHALL complete with SLVERR and leave memory unchanged.
REQ-031 Write FSM SHALL use states W_IDLE -> W_RESP -> W_IDLE.
REQ-032 In W_IDLE, awready and wready SHALL pulse high together for one cycle only when awvalid and wvalid are both high and the arbiter grants the write.
REQ-033 The bank write SHALL occur in that accept cycle, with wstrb applied per byte.
REQ-034 bvalid SHALL rise the next cycle and hold until bready.
REQ-035 Read FSM SHALL use states R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
REQ-036 arready SHALL pulse one cycle on a granted read.
REQ-037 After the BRAM cycle in R_WAIT, rdata/rresp SHALL be registered with rvalid high in R_DATA, giving rvalid 2 cycles after the arready cycle.
REQ-038 rvalid and rdata SHALL hold stable until rready.
REQ-039 Only one read and one write SHALL be outstanding at a time; no new AR/AW is accepted before the previous response handshakes.
REQ-040 The AXI port SHALL be single-ported across banks. When a write and a read are both eligible in the same cycle, a one-bit round-robin SHALL grant the one that lost last contention, with write first after reset.
REQ-041 The fabric port SHALL be independent of the AXI port. When both write the same bank and word in one cycle, the fabric write SHALL win, and the AXI write SHALL still return OKAY.
REQ-042 An AXI read of a word that the fabric writes in the same cycle SHALL return the old data.
REQ-043 A fabric write with pl_bank >= N_BANKS SHALL be ignored.

Reset
REQ-044 During rst: awready=wready=arready=bvalid=rvalid=0, bresp=rresp=00, rdata=0, pl_dout=0, FSMs idle, arbiter=write-first.
REQ-045 A transaction in flight at rst SHALL be abandoned without a response. Memory contents SHALL NOT be cleared.

Structure
REQ-046 Shared package axil_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write/read FSM state typedefs.
REQ-047 Storage SHALL be one sub-module, bram_tdp_bank (true dual-port, byte-write port A, read-first), instantiated N_BANKS times via generate.

Verification
REQ-048 Write 0x12345678 to 0x0000_0004, then read it back -> bresp=00; rdata=0x12345678 2 cycles after arready; pl_bank=0, pl_addr=1 -> pl_dout=0x12345678.
REQ-049 wstrb=0b0010, wdata=0xAABBCCDD over 0x12345678 -> readback 0x1234CC78.
REQ-050 N_BANKS=3, access bank 3 (DEPTH_LOG2=10, addr 0x3000) -> write bresp=10 with memory unchanged; read rresp=10, rdata=0.
REQ-051 AW+W and AR asserted in the same cycle for two consecutive transaction pairs -> grants alternate: write, read, then read, write.
REQ-052 Fabric and AXI write the same word in the same cycle (0x11111111 vs 0x22222222) -> memory holds 0x11111111; bresp=00.
REQ-053 rst asserted while rvalid=1 with rready=0 -> rvalid=0 the next cycle; subsequent read is correct.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the banked BRAM slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } r_state_e;

    // A single bank still gets one select bit so out-of-range accesses stay decodable.
    function automatic int bank_bits(input int n_banks);
        return (n_banks > 32'sd1) ? $clog2(n_banks) : 32'sd1;
    endfunction

endpackage

// File: rtl/axil_bram_banks_if.sv
// AXI4-Lite bus bundle (32-bit address and data) with master/slave views.
interface axil_bram_banks_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/bram_tdp_bank.sv
// One 32-bit true dual-port bank: port A byte writes, port B word writes, both read-first.
module bram_tdp_bank #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            a_we,
    input  logic [DEPTH_LOG2-1:0] a_addr,
    input  logic [31:0]           a_din,
    output logic [31:0]           a_dout,
    input  logic                  b_we,
    input  logic [DEPTH_LOG2-1:0] b_addr,
    input  logic [31:0]           b_din,
    output logic [31:0]           b_dout
);

    logic [31:0] mem_r [0:(32'sd1 << DEPTH_LOG2) - 32'sd1];

    // Storage update; port B is applied last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_we[i]) begin
                mem_r[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
        if (b_we) begin
            mem_r[b_addr] <= b_din;
        end
    end

    // Read-first output registers; only these are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout <= 32'h0000_0000;
            b_dout <= 32'h0000_0000;
        end else begin
            a_dout <= mem_r[a_addr];
            b_dout <= mem_r[b_addr];
        end
    end

endmodule

// File: rtl/axil_bram_banks.sv
// AXI-Lite slave over N_BANKS BRAM banks sharing one AXI port, plus an independent fabric port.
module axil_bram_banks
    import axil_pkg::*;
#(
    parameter  int N_BANKS    = 2,
    parameter  int DEPTH_LOG2 = 10,
    parameter  int AXI_WR_EN  = 1,
    localparam int BANK_BITS  = bank_bits(N_BANKS)
) (
    input  logic                  axi_clock,
    input  logic                  rst,
    axil_bram_banks_if.slave      s_axil,
    input  logic                  pl_we,
    input  logic [BANK_BITS-1:0]  pl_bank,
    input  logic [DEPTH_LOG2-1:0] pl_addr,
    input  logic [31:0]           pl_din,
    output logic [31:0]           pl_dout
);

    localparam int             BANK_LSB  = DEPTH_LOG2 + 2;
    localparam logic [BANK_BITS:0] N_BANKS_W = N_BANKS[BANK_BITS:0];

    function automatic logic bank_valid(input logic [BANK_BITS-1:0] bank);
        return ({1'b0, bank} < N_BANKS_W);
    endfunction

    w_state_e              w_state_r, w_next_s;
    r_state_e              r_state_r, r_next_s;
    logic                  prefer_rd_r;
    logic [1:0]            bresp_r, rresp_r;
    logic [31:0]           rdata_r;
    logic                  rd_err_r;
    logic [BANK_BITS-1:0]  rd_bank_r, pl_bank_r;

    logic [DEPTH_LOG2-1:0] wr_word_s, rd_word_s, a_addr_s;
    logic [BANK_BITS-1:0]  wr_bank_s, rd_bank_s;
    logic                  wr_elig_s, rd_elig_s, grant_w_s, grant_r_s, wr_hit_s;
    logic [31:0]           rd_mux_s, pl_mux_s;
    logic [31:0]           a_dout_s [N_BANKS];
    logic [31:0]           b_dout_s [N_BANKS];
    logic                  unused_addr_s;

    assign wr_word_s = s_axil.awaddr[DEPTH_LOG2+1:2];
    assign rd_word_s = s_axil.araddr[DEPTH_LOG2+1:2];
    assign wr_bank_s = s_axil.awaddr[BANK_LSB +: BANK_BITS];
    assign rd_bank_s = s_axil.araddr[BANK_LSB +: BANK_BITS];
    assign unused_addr_s = ^{s_axil.awaddr[31:BANK_LSB+BANK_BITS], s_axil.awaddr[1:0],
                             s_axil.araddr[31:BANK_LSB+BANK_BITS], s_axil.araddr[1:0]};

    // Single AXI port: on contention the side that lost last time goes first.
    assign wr_elig_s = !rst && (w_state_r == W_IDLE) && s_axil.awvalid && s_axil.wvalid;
    assign rd_elig_s = !rst && (r_state_r == R_IDLE) && s_axil.arvalid;
    assign grant_w_s = wr_elig_s && (!rd_elig_s || !prefer_rd_r);
    assign grant_r_s = rd_elig_s && !grant_w_s;
    assign wr_hit_s  = grant_w_s && (AXI_WR_EN != 32'sd0) && bank_valid(wr_bank_s);
    assign a_addr_s  = grant_w_s ? wr_word_s : rd_word_s;

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        logic [3:0] a_we_s;
        logic       b_we_s;
        assign a_we_s = (wr_hit_s && (wr_bank_s == BANK_BITS'(g))) ? s_axil.wstrb : 4'b0000;
        assign b_we_s = pl_we && (pl_bank == BANK_BITS'(g));

        bram_tdp_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
            .clk    (axi_clock),
            .rst    (rst),
            .a_we   (a_we_s),
            .a_addr (a_addr_s),
            .a_din  (s_axil.wdata),
            .a_dout (a_dout_s[g]),
            .b_we   (b_we_s),
            .b_addr (pl_addr),
            .b_din  (pl_din),
            .b_dout (b_dout_s[g])
        );
    end

    // Bank output selection for the AXI read path and the fabric read port.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        pl_mux_s = 32'h0000_0000;
        for (int i = 0; i < N_BANKS; i++) begin
            rd_mux_s = (rd_bank_r == BANK_BITS'(i)) ? a_dout_s[i] : rd_mux_s;
            pl_mux_s = (pl_bank_r == BANK_BITS'(i)) ? b_dout_s[i] : pl_mux_s;
        end
    end

    // Write channel next-state.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  w_next_s = grant_w_s ? W_RESP : W_IDLE;
            W_RESP:  w_next_s = s_axil.bready ? W_IDLE : W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Read channel next-state.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  r_next_s = grant_r_s ? R_WAIT : R_IDLE;
            R_WAIT:  r_next_s = R_DATA;
            R_DATA:  r_next_s = s_axil.rready ? R_IDLE : R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // State, arbiter and response registers.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            w_state_r   <= W_IDLE;
            r_state_r   <= R_IDLE;
            prefer_rd_r <= 1'b0;
            bresp_r     <= RESP_OKAY;
            rresp_r     <= RESP_OKAY;
            rdata_r     <= 32'h0000_0000;
            rd_err_r    <= 1'b0;
            rd_bank_r   <= {BANK_BITS{1'b0}};
            pl_bank_r   <= {BANK_BITS{1'b0}};
        end else begin
            w_state_r <= w_next_s;
            r_state_r <= r_next_s;
            pl_bank_r <= pl_bank;
            if (wr_elig_s && rd_elig_s) begin
                prefer_rd_r <= grant_w_s;
            end
            if (grant_w_s) begin
                bresp_r <= ((AXI_WR_EN != 32'sd0) && bank_valid(wr_bank_s)) ? RESP_OKAY : RESP_SLVERR;
            end
            if (grant_r_s) begin
                rd_bank_r <= rd_bank_s;
                rd_err_r  <= !bank_valid(rd_bank_s);
            end
            if (r_state_r == R_WAIT) begin
                rdata_r <= rd_err_r ? 32'h0000_0000 : rd_mux_s;
                rresp_r <= rd_err_r ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s_axil.awready = grant_w_s;
    assign s_axil.wready  = grant_w_s;
    assign s_axil.arready = grant_r_s;
    assign s_axil.bvalid  = (w_state_r == W_RESP);
    assign s_axil.bresp   = bresp_r;
    assign s_axil.rvalid  = (r_state_r == R_DATA);
    assign s_axil.rresp   = rresp_r;
    assign s_axil.rdata   = rdata_r;
    assign pl_dout        = pl_mux_s;

endmodule

// File: tb/tb_axil_bram_banks.sv
// Scoreboard bench: a 3-bank writable instance and a 1-bank AXI-read-only instance.
module tb_axil_bram_banks;
    import axil_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    axil_bram_banks_if bus ();
    axil_bram_banks_if ro ();

    logic        pl_we;
    logic [1:0]  pl_bank;
    logic [9:0]  pl_addr;
    logic [31:0] pl_din, pl_dout;
    logic        ro_pl_we;
    logic [0:0]  ro_pl_bank;
    logic [9:0]  ro_pl_addr;
    logic [31:0] ro_pl_din, ro_pl_dout;

    axil_bram_banks #(.N_BANKS(3), .DEPTH_LOG2(10), .AXI_WR_EN(1)) u_dut (
        .axi_clock(clk), .rst(rst), .s_axil(bus),
        .pl_we(pl_we), .pl_bank(pl_bank), .pl_addr(pl_addr), .pl_din(pl_din), .pl_dout(pl_dout)
    );

    axil_bram_banks #(.N_BANKS(1), .DEPTH_LOG2(10), .AXI_WR_EN(0)) u_ro (
        .axi_clock(clk), .rst(rst), .s_axil(ro),
        .pl_we(ro_pl_we), .pl_bank(ro_pl_bank), .pl_addr(ro_pl_addr), .pl_din(ro_pl_din), .pl_dout(ro_pl_dout)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_b = 0;
    int n_r = 0;
    int ar_cyc = 0;
    bit lat_pending = 1'b0;
    logic [1:0]  exp_b [$];
    logic [31:0] exp_rd [$];
    logic [1:0]  exp_rr [$];
    bit          grant_log [$];

    always @(posedge clk) cyc++;

    // Scoreboard side: pops expectations on every completed response handshake.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.awvalid && bus.awready) grant_log.push_back(1'b0);
            if (bus.arvalid && bus.arready) begin
                grant_log.push_back(1'b1);
                ar_cyc = cyc;
                lat_pending = 1'b1;
            end else if (lat_pending && bus.rvalid) begin
                tests++;
                if (cyc - ar_cyc != 2) begin
                    fails++;
                    $display("FAIL rvalid_latency got %0d cycles after arready, required 2", cyc - ar_cyc);
                end
                lat_pending = 1'b0;
            end
            if (bus.bvalid && bus.bready) begin
                logic [1:0] eb;
                tests++;
                n_b++;
                if (exp_b.size() == 0) begin
                    fails++;
                    $display("FAIL bresp_sb unexpected response bresp=%b, required none", bus.bresp);
                end else begin
                    eb = exp_b.pop_front();
                    if (bus.bresp !== eb) begin
                        fails++;
                        $display("FAIL bresp_sb got %b, required %b", bus.bresp, eb);
                    end
                end
            end
            if (bus.rvalid && bus.rready) begin
                logic [31:0] ed;
                logic [1:0]  er;
                tests++;
                n_r++;
                if (exp_rd.size() == 0) begin
                    fails++;
                    $display("FAIL rdata_sb unexpected response rdata=%h, required none", bus.rdata);
                end else begin
                    ed = exp_rd.pop_front();
                    er = exp_rr.pop_front();
                    if (bus.rdata !== ed || bus.rresp !== er) begin
                        fails++;
                        $display("FAIL rdata_sb got %h/%b, required %h/%b", bus.rdata, bus.rresp, ed, er);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input int target);
        for (int k = 0; k < 50 && n_b < target; k++) tick();
        if (n_b < target) begin
            tests++; fails++;
            $display("FAIL bvalid_timeout got %0d responses, required %0d", n_b, target);
        end
    endtask

    task automatic wait_r(input int target);
        for (int k = 0; k < 50 && n_r < target; k++) tick();
        if (n_r < target) begin
            tests++; fails++;
            $display("FAIL rvalid_timeout got %0d responses, required %0d", n_r, target);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, output int waited);
        int target;
        bit acc;
        target = n_b + 1;
        exp_b.push_back(er);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        acc = 1'b0;
        waited = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1;
            acc = (bus.awready === 1'b1) && (bus.wready === 1'b1);
            if (!acc) waited++;
            tick();
            pl_we = 1'b0;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL wr_accept addr=%h got no awready/wready, required a pulse", a);
        end
        wait_b(target);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                            output int waited);
        int target;
        bit acc;
        target = n_r + 1;
        exp_rd.push_back(ed);
        exp_rr.push_back(er);
        bus.araddr = a;
        bus.arvalid = 1'b1;
        acc = 1'b0;
        waited = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1;
            acc = (bus.arready === 1'b1);
            if (!acc) waited++;
            tick();
            pl_we = 1'b0;
        end
        bus.arvalid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL rd_accept addr=%h got no arready, required a pulse", a);
        end
        wait_r(target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        ro.awvalid = 1'b1; ro.wvalid = 1'b1; ro.arvalid = 1'b1;
        tick(); tick(); tick();
        #1;
        tests++;
        if ({bus.awready, bus.wready, bus.arready, ro.awready, ro.arready} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ready got %b, required 00000",
                     {bus.awready, bus.wready, bus.arready, ro.awready, ro.arready});
        end
        tests++;
        if ({bus.bvalid, bus.rvalid, ro.bvalid, ro.rvalid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_valid got %b, required 0000", {bus.bvalid, bus.rvalid, ro.bvalid, ro.rvalid});
        end
        tests++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
            fails++;
            $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h, required 0", bus.bresp, bus.rresp, bus.rdata);
        end
        tests++;
        if (pl_dout !== 32'h0 || ro_pl_dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_pl_dout got %h/%h, required 0", pl_dout, ro_pl_dout);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        ro.awvalid = 1'b0; ro.wvalid = 1'b0; ro.arvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int w;
        axi_write(32'h0000_0004, 32'h1234_5678, 4'hF, RESP_OKAY, w);
        axi_read(32'h0000_0004, 32'h1234_5678, RESP_OKAY, w);
        pl_bank = 2'd0; pl_addr = 10'd1;
        tick();
        tests++;
        if (pl_dout !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_pl_dout got %h, required 12345678", pl_dout);
        end
    endtask

    task automatic test_wstrb();
        int w;
        axi_write(32'h0000_0004, 32'hAABB_CCDD, 4'b0010, RESP_OKAY, w);
        axi_read(32'h0000_0004, 32'h1234_CC78, RESP_OKAY, w);
        axi_write(32'h0000_1008, 32'hCAFE_F00D, 4'hF, RESP_OKAY, w);
        axi_write(32'h0000_2004, 32'h2222_0001, 4'hF, RESP_OKAY, w);
        pl_bank = 2'd1; pl_addr = 10'd2;
        tick();
        tests++;
        if (pl_dout !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL bank1_pl_dout got %h, required cafef00d", pl_dout);
        end
        axi_read(32'h8000_100B, 32'hCAFE_F00D, RESP_OKAY, w);
    endtask

    task automatic test_bad_bank();
        int w;
        logic [31:0] e [3];
        e[0] = 32'h1234_CC78; e[1] = 32'h1111_0001; e[2] = 32'h2222_0001;
        pl_we = 1'b1; pl_bank = 2'd1; pl_addr = 10'd1; pl_din = 32'h1111_0001;
        tick();
        pl_we = 1'b0;
        axi_write(32'h0000_3004, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, w);
        axi_read(32'h0000_3004, 32'h0000_0000, RESP_SLVERR, w);
        pl_we = 1'b1; pl_bank = 2'd3; pl_addr = 10'd1; pl_din = 32'hBADB_AD00;
        tick();
        pl_we = 1'b0;
        for (int b = 0; b < 3; b++) begin
            pl_bank = b[1:0]; pl_addr = 10'd1;
            tick();
            tests++;
            if (pl_dout !== e[b]) begin
                fails++;
                $display("FAIL bad_bank_unchanged bank=%0d got %h, required %h", b, pl_dout, e[b]);
            end
        end
    endtask

    task automatic run_pair(input logic [31:0] wa, input logic [31:0] wd,
                            input logic [31:0] ra, input logic [31:0] rexp);
        int tb_t, tr_t;
        bit wacc, racc, wa_s, ra_s;
        exp_b.push_back(RESP_OKAY);
        exp_rd.push_back(rexp);
        exp_rr.push_back(RESP_OKAY);
        tb_t = n_b + 1; tr_t = n_r + 1;
        bus.awaddr = wa; bus.wdata = wd; bus.wstrb = 4'hF; bus.araddr = ra;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        wacc = 1'b0; racc = 1'b0;
        for (int k = 0; k < 20 && !(wacc && racc); k++) begin
            #1;
            wa_s = (bus.awready === 1'b1);
            ra_s = (bus.arready === 1'b1);
            tick();
            if (wa_s) begin wacc = 1'b1; bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
            if (ra_s) begin racc = 1'b1; bus.arvalid = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        if (!(wacc && racc)) begin
            tests++; fails++;
            $display("FAIL pair_accept got w=%0d r=%0d, required both", wacc, racc);
        end
        wait_b(tb_t);
        wait_r(tr_t);
    endtask

    task automatic test_arbiter();
        int w;
        logic [3:0] got;
        pl_we = 1'b1; pl_bank = 2'd0; pl_addr = 10'd5; pl_din = 32'h5EED_0005;
        tick();
        pl_we = 1'b0;
        grant_log.delete();
        run_pair(32'h0000_0010, 32'hA0A0_0004, 32'h0000_0014, 32'h5EED_0005);
        run_pair(32'h0000_0018, 32'hB0B0_0006, 32'h0000_0010, 32'hA0A0_0004);
        got = 4'hF;
        if (grant_log.size() == 4) got = {grant_log[3], grant_log[2], grant_log[1], grant_log[0]};
        tests++;
        if (grant_log.size() != 4 || got !== 4'b0110) begin
            fails++;
            $display("FAIL arb_order got %b (n=%0d, bit0 first, 1=read), required 0110", got, grant_log.size());
        end
        axi_read(32'h0000_0018, 32'hB0B0_0006, RESP_OKAY, w);
    endtask

    task automatic test_collision();
        int w;
        pl_we = 1'b1; pl_bank = 2'd0; pl_addr = 10'd8; pl_din = 32'h1111_1111;
        axi_write(32'h0000_0020, 32'h2222_2222, 4'hF, RESP_OKAY, w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL collide_same_cycle got accept after %0d cycles, required 0", w);
        end
        axi_read(32'h0000_0020, 32'h1111_1111, RESP_OKAY, w);
        pl_we = 1'b1; pl_bank = 2'd0; pl_addr = 10'd8; pl_din = 32'h4444_4444;
        axi_read(32'h0000_0020, 32'h1111_1111, RESP_OKAY, w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL read_first_same_cycle got accept after %0d cycles, required 0", w);
        end
        pl_addr = 10'd8;
        tick();
        tests++;
        if (pl_dout !== 32'h4444_4444) begin
            fails++;
            $display("FAIL read_first_pl_dout got %h, required 44444444", pl_dout);
        end
    endtask

    task automatic test_hold_and_reset();
        int w;
        bus.rready = 1'b0;
        bus.araddr = 32'h0000_0004;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int k = 0; k < 10 && bus.rvalid !== 1'b1; k++) tick();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1234_CC78) begin
                fails++;
                $display("FAIL rready_hold cycle=%0d got rvalid=%b rdata=%h, required 1/1234cc78", k, bus.rvalid, bus.rdata);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        tests++;
        if (bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_abandon got rvalid=%b, required 0", bus.rvalid);
        end
        rst = 1'b0;
        bus.rready = 1'b1;
        tick();
        axi_read(32'h0000_0004, 32'h1234_CC78, RESP_OKAY, w);
    endtask

    task automatic ro_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        ro.araddr = a;
        ro.arvalid = 1'b1;
        tick();
        ro.arvalid = 1'b0;
        for (int k = 0; k < 10 && ro.rvalid !== 1'b1; k++) tick();
        tests++;
        if (ro.rvalid !== 1'b1 || ro.rdata !== ed || ro.rresp !== er) begin
            fails++;
            $display("FAIL ro_read addr=%h got %b/%h/%b, required 1/%h/%b", a, ro.rvalid, ro.rdata, ro.rresp, ed, er);
        end
        tick();
    endtask

    task automatic test_read_only();
        ro_pl_we = 1'b1; ro_pl_bank = 1'b0; ro_pl_addr = 10'd5; ro_pl_din = 32'h5A5A_5A5A;
        tick();
        ro_pl_we = 1'b0;
        ro.awaddr = 32'h0000_0014; ro.wdata = 32'hFFFF_FFFF; ro.wstrb = 4'hF;
        ro.awvalid = 1'b1; ro.wvalid = 1'b1;
        #1;
        tests++;
        if (ro.awready !== 1'b1 || ro.wready !== 1'b1) begin
            fails++;
            $display("FAIL ro_wr_accept got %b%b, required 11", ro.awready, ro.wready);
        end
        tick();
        ro.awvalid = 1'b0; ro.wvalid = 1'b0;
        for (int k = 0; k < 10 && ro.bvalid !== 1'b1; k++) tick();
        tests++;
        if (ro.bvalid !== 1'b1 || ro.bresp !== RESP_SLVERR) begin
            fails++;
            $display("FAIL ro_bresp got %b/%b, required 1/10", ro.bvalid, ro.bresp);
        end
        tick();
        ro_read(32'h0000_0014, 32'h5A5A_5A5A, RESP_OKAY);
        ro_read(32'h0000_1014, 32'h0000_0000, RESP_SLVERR);
        ro_pl_addr = 10'd5;
        tick();
        tests++;
        if (ro_pl_dout !== 32'h5A5A_5A5A) begin
            fails++;
            $display("FAIL ro_pl_dout got %h, required 5a5a5a5a", ro_pl_dout);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        ro.awaddr = 32'h0; ro.awvalid = 1'b0; ro.wdata = 32'h0; ro.wstrb = 4'h0; ro.wvalid = 1'b0;
        ro.bready = 1'b1; ro.araddr = 32'h0; ro.arvalid = 1'b0; ro.rready = 1'b1;
        pl_we = 1'b0; pl_bank = 2'd0; pl_addr = 10'd0; pl_din = 32'h0;
        ro_pl_we = 1'b0; ro_pl_bank = 1'b0; ro_pl_addr = 10'd0; ro_pl_din = 32'h0;
        test_reset();
        test_basic();
        test_wstrb();
        test_bad_bank();
        test_arbiter();
        test_collision();
        test_hold_and_reset();
        test_read_only();
        tick();
        tests++;
        if (exp_b.size() != 0 || exp_rd.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d/%0d pending, required 0/0", exp_b.size(), exp_rd.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion by 200000, required finish");
        $fatal(1, "watchdog");
    end

endmodule
